// File: rtl/spi_reg_ctrl_if.sv
// SPI bus bundle between an external master and spi_reg_ctrl.
// The master modport drives the bus; the slave modport is the controller's view.
`timescale 1ns/1ps
interface spi_reg_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 register controller: decodes 16-bit write frames into five PWM config registers.
// Optional readback of register contents on cipo is enabled by defining SPI_READBACK_EN.
`timescale 1ns/1ps
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_ctrl_if.slave  spi,
  output logic [7:0]     en_reg_out_7_0,
  output logic [7:0]     en_reg_out_15_8,
  output logic [7:0]     en_reg_pwm_7_0,
  output logic [7:0]     en_reg_pwm_15_8,
  output logic [7:0]     pwm_duty_cycle,
  output logic           wr_pulse
);

  localparam int         NUM_REGS = 5;
  localparam logic [6:0] MAX_A    = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  // NOTE: synchronizer and edge flops are deliberately not reset; they keep tracking
  // the pins during reset so a frame already in flight cannot fake an ncs fall on release.
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
    copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
    ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
    sclk_prev_q <= sclk_s;
    ncs_prev_q  <= ncs_s;
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic        wr_pulse_q;
  logic        clr_cnt, shift_en, commit_en, frame_ok;

  assign frame_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_A);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = frame_ok ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      IDLE:    clr_cnt   = 1'b1;
      SHIFT:   shift_en  = sclk_rise & ~ncs_s;
      COMMIT:  commit_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[14:0], copi_s};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Addresses above the last physical register but within MAX_ADDR still pulse, but store nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= commit_en;
      if (commit_en) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_pulse        = wr_pulse_q;

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rd_hdr;
  logic [7:0] rd_val;
  logic [7:0] out_q, out_d;

  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // Header byte as it will stand once the 8th bit (address LSB) lands.
  assign rd_hdr    = {shift_q[6:0], copi_s};

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hdr[6:0] == 7'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    out_d = out_q;
    if (ncs_rise) begin
      out_d = '0;
    end else if (shift_en && (cnt_q == 5'd7)) begin
      out_d = (!rd_hdr[7] && (rd_hdr[6:0] <= MAX_A)) ? rd_val : 8'h00;
    end else if ((state_q == SHIFT) && sclk_fall && !ncs_s) begin
      out_d = {out_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign spi.cipo = out_q[7];
`else
  assign spi.cipo = 1'b0;
`endif

endmodule
